// File: rtl/and_vec_pkg.sv
// Shared types and constants for the AND-gate stimulus sequencer.
package and_vec_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;
  localparam int NUM_VECTORS = 4;
  localparam int VEC_W       = 2;
endpackage

// File: rtl/and_vec_checker.sv
// Compares the returned gate output at each sample strobe; pulses mismatch
// one cycle later and keeps a saturating error count until cleared.
module and_vec_checker #(
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe_i,
  input  logic             exp_i,
  input  logic             s_i,
  input  logic             clr_i,
  output logic             mismatch_o,
  output logic [ERR_W-1:0] err_cnt_o
);
  logic             mismatch_q, mismatch_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fail;

  assign fail = strobe_i && (s_i != exp_i);

  always_comb begin
    mismatch_d = fail;
    err_d      = err_q;
    if (clr_i) begin
      mismatch_d = 1'b0;
      err_d      = '0;
    end else if (fail && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else begin
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
    end
  end

  assign mismatch_o = mismatch_q;
  assign err_cnt_o  = err_q;
endmodule

// File: rtl/and_vec_driver.sv
// Clocked sequencer sweeping the AND gate inputs through 00..11, holding each
// vector HOLD_CYCLES cycles for NUM_PASSES sweeps. Checking under AND_VEC_CHECK_EN.
module and_vec_driver
  import and_vec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int NUM_PASSES  = 1,
  parameter int ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_in,
  output logic             a,
  output logic             b,
  output logic [1:0]       vec_idx,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int PW = $clog2(NUM_PASSES + 1);

  state_t           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [PW-1:0]    pass_q, pass_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             last_hold, accept, sample;

  assign last_hold = (hold_q == HW'(HOLD_CYCLES - 1));
  assign accept    = (state_q == IDLE) && start;
  assign sample    = (state_q == APPLY) && last_hold;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pass_d  = pass_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = APPLY;
        hold_d  = '0;
        pass_d  = '0;
        vec_d   = '0;
      end
      APPLY: begin
        hold_d = hold_q + HW'(1);
        if (last_hold) begin
          hold_d = '0;
          vec_d  = vec_q + VEC_W'(1);
          if (vec_q == VEC_W'(NUM_VECTORS - 1)) begin
            pass_d = pass_q + PW'(1);
            if (pass_q == PW'(NUM_PASSES - 1)) begin
              state_d = DONE;
              pass_d  = '0;
              vec_d   = '0;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      pass_q  <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pass_q  <= pass_d;
      vec_q   <= vec_d;
    end
  end

  assign vec_idx = vec_q;
  assign a       = vec_q[1];
  assign b       = vec_q[0];
  assign busy    = (state_q == APPLY);
  assign done    = (state_q == DONE);

`ifdef AND_VEC_CHECK_EN
  // Expected value is the a&b being driven before this edge's vector update.
  and_vec_checker #(.ERR_W(ERR_W)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .strobe_i  (sample),
    .exp_i     (a & b),
    .s_i       (s_in),
    .clr_i     (accept),
    .mismatch_o(mismatch),
    .err_cnt_o (err_cnt)
  );
`else
  logic unused_chk;
  assign unused_chk = s_in ^ sample ^ accept;
  assign mismatch   = 1'b0;
  assign err_cnt    = '0;
`endif
endmodule
